// File: rtl/unidade_controle_exp2.sv
// Control FSM for the counter/comparator search: clears the counter, counts until
// the count matches the switches, then reports hit (acerto) or overrun (erro).
module unidade_controle_exp2 (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       pausa,
   input  logic       igual,
   input  logic       fim,
   output logic       zera,
   output logic       conta,
   output logic       pronto,
   output logic       acertou,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL    = 4'b0000,
      PREPARACAO = 4'b0001,
      CONTAGEM   = 4'b0010,
      PAUSADO    = 4'b0011,
      ACERTO     = 4'b1010,
      ERRO       = 4'b1110
   } estado_t;

   estado_t estado_q, estado_d;

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // the pre-edge value; blocking here would create simulation/synthesis races.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado_q <= INICIAL;
      else       estado_q <= estado_d;
   end

   // NOTE: estado_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL:    if (iniciar) estado_d = PREPARACAO;
         PREPARACAO: estado_d = CONTAGEM;
         CONTAGEM: begin
            // igual beats fim so chaves=15 ends in acerto rather than erro
            if      (igual) estado_d = ACERTO;
            else if (fim)   estado_d = ERRO;
            else if (pausa) estado_d = PAUSADO;
         end
         PAUSADO:    if (!pausa) estado_d = CONTAGEM;
         ACERTO,
         ERRO:       if (iniciar) estado_d = PREPARACAO;
         default:    estado_d = INICIAL;
      endcase
   end

   always_comb begin
      zera    = (estado_q == PREPARACAO);
      // Mealy enable: freezes the counter on the matching value, never wraps
      conta   = (estado_q == CONTAGEM) & ~igual & ~fim & ~pausa;
      pronto  = (estado_q == ACERTO) | (estado_q == ERRO);
      acertou = (estado_q == ACERTO);
   end

   assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_exp2.sv
// Directed bench for unidade_controle_exp2, with a small counter/comparator
// datapath model closing the loop through zera/conta and igual/fim.
module tb_unidade_controle_exp2;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar;
   logic       pausa;
   logic       igual;
   logic       fim;
   logic       zera;
   logic       conta;
   logic       pronto;
   logic       acertou;
   logic [3:0] db_estado;

   logic [3:0] chaves;
   logic [3:0] cnt = 4'd0;

   int n_cmp = 0;
   int n_err = 0;

   unidade_controle_exp2 dut (
      .clock     (clock),
      .reset     (reset),
      .iniciar   (iniciar),
      .pausa     (pausa),
      .igual     (igual),
      .fim       (fim),
      .zera      (zera),
      .conta     (conta),
      .pronto    (pronto),
      .acertou   (acertou),
      .db_estado (db_estado)
   );

   always #5 clock = ~clock;

   // Datapath model: counter is not reset by the FSM reset, only by zera
   always @(posedge clock) begin
      if (zera)       cnt <= 4'd0;
      else if (conta) cnt <= cnt + 4'd1;
   end
   assign igual = (cnt == chaves);
   assign fim   = (cnt == 4'hF);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start();
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      #1;
      check("prep_state", db_estado, 4'h1);
      check("prep_outs", {zera, conta, pronto, acertou}, 4'b1000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int g;
      int c;

      reset = 1'b1; iniciar = 1'b0; pausa = 1'b0; chaves = 4'd0;
      #3;
      check("rst_state", db_estado, 4'h0);
      check("rst_outs", {zera, conta, pronto, acertou}, 4'b0000);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         tick(); #1;
         check("idle_state", db_estado, 4'h0);
         check("idle_outs", {zera, conta, pronto, acertou}, 4'b0000);
      end

      // chaves=5: conta in cycles 2..6, acerto from cycle 8
      chaves = 4'd5;
      start();
      for (int i = 0; i < 5; i++) begin
         tick(); #1;
         check("c5_conta", conta, 1'b1);
         check("c5_cnt", cnt, i);
      end
      tick(); #1;
      check("c5_match_conta", conta, 1'b0);
      check("c5_match_cnt", cnt, 4'd5);
      check("c5_match_state", db_estado, 4'h2);
      tick(); #1;
      check("c5_acerto_state", db_estado, 4'hA);
      check("c5_acerto_outs", {zera, conta, pronto, acertou}, 4'b0011);
      tick(); #1;
      check("c5_hold_state", db_estado, 4'hA);
      check("c5_hold_cnt", cnt, 4'd5);

      // chaves=0: match on first counting cycle, zero increments
      chaves = 4'd0;
      start();
      tick(); #1;
      check("c0_state", db_estado, 4'h2);
      check("c0_conta", conta, 1'b0);
      tick(); #1;
      check("c0_acerto", db_estado, 4'hA);
      check("c0_cnt", cnt, 4'd0);

      // chaves=15: igual and fim together, igual wins, no wrap
      chaves = 4'd15;
      start();
      for (int i = 0; i < 15; i++) begin
         tick(); #1;
         check("c15_cnt", cnt, i);
         check("c15_conta", conta, 1'b1);
      end
      tick(); #1;
      check("c15_top_cnt", cnt, 4'hF);
      check("c15_top_conta", conta, 1'b0);
      tick(); #1;
      check("c15_state", db_estado, 4'hA);
      check("c15_outs", {zera, conta, pronto, acertou}, 4'b0011);
      tick(); #1;
      check("c15_nowrap", cnt, 4'hF);

      // chaves=3 switched to 2 at count 3: overrun to 15, erro
      chaves = 4'd3;
      start();
      repeat (4) tick();
      chaves = 4'd2;
      #1;
      check("err_cnt3", cnt, 4'd3);
      check("err_conta3", conta, 1'b1);
      g = 0;
      while (db_estado == 4'h2 && g < 30) begin
         tick(); #1;
         g++;
      end
      check("err_edges", g, 13);
      check("err_state", db_estado, 4'hE);
      check("err_outs", {zera, conta, pronto, acertou}, 4'b0010);
      check("err_cnt", cnt, 4'hF);

      // chaves=6 with pausa high in cycles 4..7: acerto at cycle 14 instead of 9
      chaves = 4'd6;
      start();
      c = 1;
      while (db_estado != 4'hA && c < 40) begin
         tick();
         c++;
         pausa = (c >= 4 && c <= 7);
         #1;
         if (c == 4) check("p_enter_conta", conta, 1'b0);
         if (c >= 5 && c <= 8) begin
            check("p_state", db_estado, 4'h3);
            check("p_conta", conta, 1'b0);
            check("p_cnt", cnt, 4'd2);
         end
      end
      pausa = 1'b0;
      check("p_latency", c, 14);
      check("p_cnt_final", cnt, 4'd6);

      // Reset mid-count at 7, counter holds, then restart with iniciar held high
      chaves = 4'd9;
      start();
      repeat (8) tick();
      #1;
      check("r_cnt7", cnt, 4'd7);
      check("r_conta_pre", conta, 1'b1);
      reset = 1'b1;
      #1;
      check("r_state_now", db_estado, 4'h0);
      check("r_outs_now", {zera, conta, pronto, acertou}, 4'b0000);
      tick(); #1;
      check("r_cnt_hold", cnt, 4'd7);
      reset = 1'b0;
      iniciar = 1'b1;
      tick(); #1;
      check("r_prep", db_estado, 4'h1);
      tick(); #1;
      check("r_count_state", db_estado, 4'h2);
      check("r_restart_cnt", cnt, 4'd0);
      tick(); #1;
      check("r_iniciar_ignored", db_estado, 4'h2);
      check("r_cnt1", cnt, 4'd1);
      iniciar = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
